// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Purpose : Shared constants for the multicycle MIPS control path.
//           Contains the opcode values, the aluop encodings and the
//           controller state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Opcode field, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // aluop: controller-to-ALU-decoder operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Controller states. Codes 12-15 are unused.
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWR    = 4'd5,
    ST_EXECUTE  = 4'd6,
    ST_ALUWB    = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_ADDIEXEC = 4'd9,
    ST_ADDIWB   = 4'd10,
    ST_JUMP     = 4'd11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/aludec.sv
`default_nettype none
// ============================================================================
// Module  : aludec
// Purpose : ALU decoder. Maps the controller's aluop and the R-type funct
//           field onto the 3-bit ALU operation code.
// Ports   : aluop      in  2  operation class from the controller
//           funct      in  6  instruction bits [5:0]
//           alucontrol out 3  ALU operation (010 add, 110 sub, 000 and,
//                             001 or, 111 slt)
// Revision: 1.0 - initial release
// ============================================================================
module aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      ALUOP_ADD: alucontrol = 3'b010;
      ALUOP_SUB: alucontrol = 3'b110;
      ALUOP_FUNCT: begin
        case (funct)
          6'b100000: alucontrol = 3'b010; // add
          6'b100010: alucontrol = 3'b110; // sub
          6'b100100: alucontrol = 3'b000; // and
          6'b100101: alucontrol = 3'b001; // or
          6'b101010: alucontrol = 3'b111; // slt
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_ctrl
// Purpose : Moore sequencing controller for the multicycle MIPS datapath.
//           Steps each instruction through fetch/decode/execute/memory/
//           writeback, drives mux selects and write strobes, and waits on
//           the memory ready handshake in FETCH, MEMRD and MEMWR.
// Config  : MULTICYCLE_ADDI_EN - when defined, addi is executed through
//           ADDIEXEC/ADDIWB; otherwise op 001000 is reported as illegal.
// Ports   : clk, reset_n (async, active low)
//           op, funct, zero, mem_ready             - inputs
//           mem_req, memwrite, irwrite, iord, regdst, memtoreg, regwrite,
//           alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal, state
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic       w_mem_req, w_memwrite, w_irwrite, w_regwrite;
  logic       w_pcwrite, w_branch, w_illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = ST_FETCH;
    w_mem_req  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    w_aluop    = ALUOP_ADD;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    case (r_state)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        alusrcb   = 2'b01;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
        w_next    = mem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        // Branch target computed early: PC + (SignImm << 2)
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = ST_MEMADR;
          OP_RTYPE:     w_next = ST_EXECUTE;
          OP_BEQ:       w_next = ST_BRANCH;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      w_next = ST_ADDIEXEC;
`endif
          OP_J:         w_next = ST_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        w_mem_req = 1'b1;
        iord      = 1'b1;
        w_next    = mem_ready ? ST_MEMWB : ST_MEMRD;
      end
      ST_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      ST_MEMWR: begin
        w_mem_req  = 1'b1;
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_next     = mem_ready ? ST_FETCH : ST_MEMWR;
      end
      ST_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
        w_next  = ST_ALUWB;
      end
      ST_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      ST_BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      ST_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        w_regwrite = 1'b1;
      end
`endif
      ST_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = ST_FETCH;
    endcase
  end

  // While reset is held the state already reads FETCH (async clear), so the
  // selects are at their FETCH values; only the strobes need masking.
  assign mem_req  = reset_n & w_mem_req;
  assign memwrite = reset_n & w_memwrite;
  assign irwrite  = reset_n & w_irwrite;
  assign regwrite = reset_n & w_regwrite;
  assign illegal  = reset_n & w_illegal;
  assign pcen     = reset_n & (w_pcwrite | (w_branch & zero));
  assign state    = r_state;

  aludec u_aludec (
    .aluop      (w_aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_ctrl
// Purpose : Directed self-checking bench for multicycle_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, memwrite, irwrite, iord, regdst, memtoreg, regwrite;
  logic       alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .iord       (iord),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 2 time units
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // From FETCH with zero wait: issue op, step through FETCH and DECODE.
  task automatic fetch_decode(input logic [5:0] o);
    op        = o;
    mem_ready = 1'b1;
    #1;
    check("fd_fetch", state, 4'd0);
    tick();
    check("fd_decode", state, 4'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] lw_seq [6];
    int cycles;
    lw_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

    reset_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    #3;
    check("rst_state", state, 4'd0);
    check("rst_strobes", {mem_req, irwrite, pcen, memwrite, regwrite, illegal}, 6'd0);
    check("rst_selects", {iord, alusrca, alusrcb, pcsrc}, 6'b000100);
    tick();
    reset_n = 1'b1;
    #1;
    check("rel_irwrite_pcen", {irwrite, pcen, mem_req}, 3'b111);

    // FETCH wait state
    mem_ready = 1'b0;
    #1;
    check("fetch_wait_ir", {irwrite, pcen}, 2'b00);
    tick();
    check("fetch_hold", state, 4'd0);

    // lw, zero wait states: 0,1,2,3,4,0
    op = 6'b100011; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("lw_state", state, lw_seq[i]);
      check("lw_wb", {regwrite, memtoreg}, (lw_seq[i] == 4'd4) ? 2'b11 : 2'b00);
      if (i < 5) tick();
    end

    // sw with 3 wait cycles in MEMWR
    cycles = 0;
    fetch_decode(6'b101011);
    cycles = 2;
    check("sw_memadr", state, 4'd2);
    tick(); cycles++;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sw_wait_memwrite", {state, memwrite, mem_req, iord}, {4'd5, 3'b111});
      tick(); cycles++;
    end
    mem_ready = 1'b1;
    #1;
    check("sw_last_memwrite", {state, memwrite}, {4'd5, 1'b1});
    tick(); cycles++;
    check("sw_done", state, 4'd0);
    check("sw_cycles", cycles, 7);

    // R-type sub
    funct = 6'b100010;
    fetch_decode(6'b000000);
    check("r_exec", {state, alucontrol, alusrca, alusrcb}, {4'd6, 3'b110, 1'b1, 2'b00});
    tick();
    check("r_aluwb", {state, regdst, regwrite, memtoreg}, {4'd7, 3'b110});
    tick();
    check("r_done", state, 4'd0);

    // beq taken
    zero = 1'b1;
    op = 6'b000100; mem_ready = 1'b1;
    tick();
    check("beq_decode_pcen", {state, pcen, alusrcb}, {4'd1, 1'b0, 2'b11});
    tick();
    check("beq_taken", {state, pcen, pcsrc, alucontrol}, {4'd8, 1'b1, 2'b01, 3'b110});
    tick();
    check("beq_done", state, 4'd0);

    // beq not taken
    zero = 1'b0;
    fetch_decode(6'b000100);
    check("beq_not_taken", {state, pcen}, {4'd8, 1'b0});
    tick();

    // j
    fetch_decode(6'b000010);
    check("jump", {state, pcsrc, pcen}, {4'd11, 2'b10, 1'b1});
    tick();
    check("jump_done", state, 4'd0);

    // addi
    op = 6'b001000;
    tick();
    check("addi_decode_illegal",
`ifdef MULTICYCLE_ADDI_EN
          illegal, 1'b0);
`else
          illegal, 1'b1);
`endif
    tick();
`ifdef MULTICYCLE_ADDI_EN
    check("addi_exec", {state, alusrca, alusrcb}, {4'd9, 1'b1, 2'b10});
    tick();
    check("addi_wb", {state, regwrite, regdst, memtoreg}, {4'd10, 3'b100});
    tick();
`endif
    check("addi_done", state, 4'd0);

    // unsupported opcode
    op = 6'b111111;
    tick();
    check("ill_decode", {state, illegal}, {4'd1, 1'b1});
    tick();
    check("ill_fetch", {state, illegal}, {4'd0, 1'b0});

    // reset during MEMWR wait
    fetch_decode(6'b101011);
    tick();
    mem_ready = 1'b0;
    #1;
    check("pre_rst_memwr", {state, memwrite}, {4'd5, 1'b1});
    reset_n = 1'b0;
    #1;
    check("async_rst", {state, memwrite, mem_req}, {4'd0, 2'b00});
    tick();
    check("rst_hold", {state, memwrite, mem_req, irwrite}, {4'd0, 3'b000});
    mem_ready = 1'b1;
    reset_n = 1'b1;
    #1;
    check("rst_rel_fetch", {state, irwrite, pcen}, {4'd0, 2'b11});
    tick();
    check("rst_rel_decode", state, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing controller for the multicycle MIPS processor: a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects and write strobes, and stalls on a memory ready handshake. It instantiates the existing ALU decoder to produce `alucontrol`. It replaces the single-cycle main decoder and sits between the instruction register and the datapath.

## Interface
- No parameters. Opcode and state encodings are fixed constants (see Structure).
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 6: opcode from the instruction register, bits [31:26].
- `funct` in 6: funct field, bits [5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `mem_req` out 1: memory access active.
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: instruction register load.
- `iord` out 1: address select; 0 = PC, 1 = ALUOut.
- `regdst` out 1: destination select; 1 = rd, 0 = rt.
- `memtoreg` out 1: writeback select; 1 = data register, 0 = ALUOut.
- `regwrite` out 1: register file write.
- `alusrca` out 1: ALU A select; 0 = PC, 1 = A.
- `alusrcb` out 2: ALU B select; 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc` out 2: PC source; 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `pcen` out 1: PC enable; pcen = pcwrite | (branch & zero).
- `alucontrol` out 3: ALU operation, produced by the ALU decoder from the internal aluop and `funct`.
- `illegal` out 1: one-cycle pulse in DECODE when `op` is unsupported.
- `state` out 4: current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12–15 are unused and return to FETCH.
- FETCH:
  - mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcwrite equal `mem_ready`.
  - Stays in FETCH while mem_ready=0; moves to DECODE when it is 1.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by `op`:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXECUTE.
  - 000100 (beq) → BRANCH.
  - 001000 (addi) → ADDIEXEC.
  - 000010 (j) → JUMP.
  - Any other opcode: `illegal`=1, → FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw → MEMRD; sw → MEMWR.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready=1, then → MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. → FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Holds until mem_ready=1, then → FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. → ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. → FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. → FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, aluop=00. → ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. → FETCH.
- JUMP: pcsrc=10, pcwrite=1. → FETCH.
- Any signal not listed for a state is 0 in that state.
- The decision in DECODE and MEMADR uses `op` as sampled at that clock edge. The instruction register holds `op` stable because irwrite is only asserted in FETCH.

## Timing
- All outputs are combinational from `state`, plus `mem_ready`, `zero` and `op` where listed. There is no output register.
- `reset_n` low:
  - state goes to FETCH immediately, without waiting for a clock edge.
  - mem_req, memwrite, irwrite, pcwrite, pcen, regwrite and illegal are forced to 0.
  - The mux selects take their FETCH values.
- Reset deasserted: the first rising edge after release evaluates FETCH normally.
- Reset asserted mid-instruction (including during a MEMWR wait): the instruction is abandoned and no strobe is asserted after the reset edge.
- Cycle counts with zero wait states:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_ready` is ignored in every state that does not assert mem_req.
- aluop encodings: 00 = add, 01 = subtract, 10 = decode from `funct`.

## Configuration
- `MULTICYCLE_ADDI_EN`:
  - Defined: ADDIEXEC and ADDIWB are built, and addi executes as described above.
  - Undefined: those states are not built, and op 001000 is treated as illegal (`illegal` pulse, → FETCH).

## Structure
- Shared package `mips_pkg`:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - State encodings.
  - aluop encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT.
- Sub-module: one instance of the existing `aludec`, fed by the internal aluop and `funct`.
- The block itself is a state register plus next-state and output logic.

## Test plan
- Reset: hold reset_n=0 from state MEMWR → state=0 immediately, memwrite=0, mem_req=0. On release with mem_ready=1 → irwrite=1 and pcen=1 in the first cycle.
- lw with mem_ready tied to 1 → state sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. Total 5 cycles.
- sw with mem_ready=0 for 3 cycles in MEMWR → memwrite held high for 4 cycles, then FETCH. Total 7 cycles.
- R-type, funct=100010 → EXECUTE with alucontrol=110, then ALUWB with regdst=1 and regwrite=1.
- beq:
  - zero=1 in BRANCH → pcen=1, pcsrc=01.
  - zero=0 → pcen=0.
  - j → pcsrc=10, pcen=1.
- op=001000:
  - With `MULTICYCLE_ADDI_EN` → states 0,1,9,10,0.
  - Without it → illegal=1 in DECODE, then FETCH.
  - op=111111 → illegal=1 in both builds.
